arith_arbiter: RTL

ARITH_ARBITER -- requirements
Module: arith_arbiter

---
 rtl/arith_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/arith_arbiter.sv
// Two-requester round-robin arbiter sharing one 4-bit add/subtract unit,
// with a single registered response slot and saturating per-requester counters.

module ArithmeticUnit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] result,
    output logic       carry,
    output logic       overflow
);

    logic [4:0] wide;

    // For subtraction the fifth bit of the 5-bit difference is the borrow (a < b).
    always_comb begin
        if (sel) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
        result = wide[3:0];
        carry  = wide[4];
        if (sel) begin
            overflow = (a[3] != b[3]) && (result[3] != a[3]);
        end else begin
            overflow = (a[3] == b[3]) && (result[3] != a[3]);
        end
    end

endmodule

module arith_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req0_sel,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic             req1_sel,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic       accept_ok;
    logic       any_valid;
    logic       grant;
    logic       xfer;
    logic       consume;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;

    // On a tie the requester not granted last time wins.
    always_comb begin
        accept_ok = (state_q == EMPTY) || rsp_ready;
        any_valid = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        xfer       = !rst && accept_ok && any_valid;
        req0_ready = xfer && (grant == 1'b0);
        req1_ready = xfer && (grant == 1'b1);
        consume    = (state_q == FULL) && rsp_ready;
        alu_a      = grant ? req1_a   : req0_a;
        alu_b      = grant ? req1_b   : req0_b;
        alu_sel    = grant ? req1_sel : req0_sel;
    end

    ArithmeticUnit u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .sel      (alu_sel),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_overflow)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;

        if (consume) begin
            if (rsp_id_q == 1'b0) begin
                cnt0_d = (cnt0_q == '1) ? cnt0_q : cnt0_q + CNT_ONE;
            end else begin
                cnt1_d = (cnt1_q == '1) ? cnt1_q : cnt1_q + CNT_ONE;
            end
        end

        if (xfer) begin
            state_d        = FULL;
            last_grant_d   = grant;
            rsp_id_d       = grant;
            rsp_result_d   = alu_result;
            rsp_carry_d    = alu_carry;
            rsp_overflow_d = alu_overflow;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    // Reset discards any pending response without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= EMPTY;
            last_grant_q   <= 1'b1;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= 4'd0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            cnt0_q         <= '0;
            cnt1_q         <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            cnt0_q         <= cnt0_d;
            cnt1_q         <= cnt1_d;
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign cnt0         = cnt0_q;
    assign cnt1         = cnt1_q;

endmodule
